// File: rtl/fib_readback_checker.sv
// Scans register-file read port A across all entries, shows each on the display for DWELL cycles,
// and verifies the Fibonacci recurrence, latching the index of the first entry that breaks it.
module fib_readback_checker #(
  parameter int DWELL = 5,
  parameter int NREGS = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic [3:0]  ReadSel,
  input  logic [15:0] ReadData,
  output logic [15:0] Display,
  output logic [3:0]  Index,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [3:0]  ErrorIndex
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4
  } stateT;

  localparam logic [3:0]  LastIdx   = 4'(NREGS - 1);
  localparam logic [15:0] DwellLast = 16'(DWELL - 1);

  stateT       stateR;
  logic [3:0]  idxR;
  logic [15:0] prev1R;
  logic [15:0] prev2R;
  logic [15:0] dwellR;
  logic        startMetaR;
  logic        startSyncR;
  logic        startPrevR;
  logic        startEdgeS;
  logic [15:0] expectedSumS;
  logic        mismatchS;

  // Two-flop synchronizer plus history flop; idle level of the button is high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      startMetaR <= 1'b1;
      startSyncR <= 1'b1;
      startPrevR <= 1'b1;
    end else begin
      startMetaR <= Start;
      startSyncR <= startMetaR;
      startPrevR <= startSyncR;
    end
  end

  // Press detection and recurrence check; the sum wraps at 16 bits by construction.
  always_comb begin
    startEdgeS   = startPrevR & ~startSyncR;
    expectedSumS = prev1R + prev2R;
    if (idxR >= 4'd2) begin
      mismatchS = (ReadData != expectedSumS);
    end else begin
      mismatchS = 1'b0;
    end
  end

  // Scan sequencer with registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateR     <= IDLE;
      idxR       <= 4'd0;
      prev1R     <= 16'd0;
      prev2R     <= 16'd0;
      dwellR     <= 16'd0;
      ReadSel    <= 4'd0;
      Display    <= 16'd0;
      Index      <= 4'd0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      ErrorIndex <= 4'd0;
    end else begin
      case (stateR)
        IDLE: begin
          Done <= 1'b0;
          if (startEdgeS) begin
            idxR       <= 4'd0;
            ReadSel    <= 4'd0;
            Error      <= 1'b0;
            ErrorIndex <= 4'd0;
            prev1R     <= 16'd0;
            prev2R     <= 16'd0;
            Busy       <= 1'b1;
            stateR     <= ADDR;
          end else begin
            Busy <= 1'b0;
          end
        end
        ADDR: begin
          stateR <= CAPTURE;
        end
        CAPTURE: begin
          Display <= ReadData;
          Index   <= idxR;
          if (mismatchS && !Error) begin
            Error      <= 1'b1;
            ErrorIndex <= idxR;
          end else begin
            Error <= Error;
          end
          prev2R <= prev1R;
          prev1R <= ReadData;
          dwellR <= 16'd0;
          stateR <= HOLD;
        end
        HOLD: begin
          dwellR <= dwellR + 16'd1;
          if (dwellR == DwellLast) begin
            if (idxR == LastIdx) begin
              Busy   <= 1'b0;
              Done   <= 1'b1;
              stateR <= DONE;
            end else begin
              idxR    <= idxR + 4'd1;
              ReadSel <= idxR + 4'd1;
              stateR  <= ADDR;
            end
          end else begin
            stateR <= HOLD;
          end
        end
        DONE: begin
          Done   <= 1'b0;
          Busy   <= 1'b0;
          stateR <= IDLE;
        end
        default: begin
          Busy   <= 1'b0;
          Done   <= 1'b0;
          stateR <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fib_readback_checker.md
# fib_readback_checker

Read-side companion to the Fibonacci sequence writer. After the writer has filled register-file entries 0..15, this block walks read port A through every entry, holds each value on the board display for a programmable dwell time, and checks that each entry from index 2 up equals the sum of the two entries before it. It sits between the `RegFile2` A read port and the 16-bit display output. It reports a sticky mismatch flag and the index of the first failing entry.

## Interface
Parameters:
- `DWELL`, 5: HOLD-state cycles per register; legal range 1..2^16-1.
- `NREGS`, 16: number of entries scanned; must be ≥3 and ≤16.

Ports:
- `Clock`  in  1: single system clock; all state on rising edge.
- `Reset`  in  1: asynchronous, active-low; forces all state and outputs to reset values immediately.
- `Start`  in  1: active-low pushbutton; passed through a 2-flop synchronizer, then falling-edge detected.
- `ReadSel`  out  4: registered select to `RegFile2` SelectA.
- `ReadData`  in  16: combinational read data for `ReadSel`; settles within one cycle.
- `Display`  out  16: currently displayed register value.
- `Index`  out  4: index of the value on `Display`.
- `Busy`  out  1: high while scanning.
- `Done`  out  1: one-cycle pulse at scan end.
- `Error`  out  1: sticky; set on the first mismatch, cleared only at the next scan start or by reset.
- `ErrorIndex`  out  4: index of the first mismatch; 0 when `Error`=0.

## Operation
- **Reset values:** `ReadSel`=0, `Display`=0, `Index`=0, `Busy`=0, `Done`=0, `Error`=0, `ErrorIndex`=0, state=IDLE, internal `idx`=0, `prev1`=0, `prev2`=0, dwell counter=0.
- **IDLE:**
  - `Busy`=0; `Display`, `Index`, `Error` and `ErrorIndex` hold their last values.
  - On a detected Start edge: `idx`←0, `ReadSel`←0, `Error`←0, `ErrorIndex`←0, `prev1`←0, `prev2`←0, go to ADDR.
- **ADDR (1 cycle):**
  - `ReadSel`=`idx` is stable; this is the regfile settle cycle.
  - Go to CAPTURE.
- **CAPTURE (1 cycle):**
  - `Display`←`ReadData`, `Index`←`idx`.
  - If `idx`≥2 and `ReadData` ≠ (`prev1`+`prev2`) mod 2^16 and `Error`=0: `Error`←1, `ErrorIndex`←`idx`.
  - Shift history: `prev2`←`prev1`, `prev1`←`ReadData`.
  - Clear the dwell counter; go to HOLD.
- **HOLD (`DWELL` cycles):**
  - Increment the dwell counter.
  - When it reaches `DWELL`-1:
    - If `idx`=`NREGS`-1, go to DONE.
    - Otherwise `idx`←`idx`+1, `ReadSel`←`idx`+1, go to ADDR.
- **DONE (1 cycle):**
  - `Done`=1, `Busy`=0; go to IDLE.
  - `Display` keeps the last entry.
- **Arithmetic:** 16-bit unsigned; the sum is truncated (wrap-around is legal and is not an error). Entries 0 and 1 are seeds and are never checked.
- **Only the first mismatch is recorded;** later mismatches do not change `ErrorIndex`.
- **Start edges are ignored in ADDR, CAPTURE, HOLD and DONE** (no restart, no queueing).
- **The block never writes the register file.** Sharing the A port with the writer is the top level's responsibility; the writer must be idle while `Busy`=1.

## Timing
- `Busy` is high in ADDR, CAPTURE and HOLD.
- **Start latency:** `Start` low sampled at edge k → synchronized at k+1 → edge detected, state=ADDR and `Busy`=1 after edge k+2.
- **Per entry:** `DWELL`+2 cycles. `Display` updates on the edge that leaves CAPTURE.
- **Full scan:** `NREGS`·(`DWELL`+2) cycles in ADDR/CAPTURE/HOLD, then 1 cycle of `Done`. Defaults: 112 busy cycles, `Done` in cycle 113.
- **Error timing:** `Error` rises on the same edge on which `Display` shows the failing value.
- **`Start` held low:** counts as one edge only; a new scan needs a release of at least 2 cycles followed by a new press.
- **Reset mid-scan:** immediate return to reset values; no `Done` pulse; a fresh Start is required afterwards.

## Test plan
- **Normal scan:** regfile preloaded 1,1,2,3,…,987 (F1..F16), `DWELL`=5, press Start → `Busy` for 112 cycles, `Display` steps 1,1,2,…,987 with `Index` 0..15, one `Done` pulse, `Error`=0.
- **Corruption:** entry 7 = 0x0014 instead of 0x0015 → `Error`=1 and `ErrorIndex`=7 at the entry-7 capture. Entries 8 and 9 also mismatch, but `ErrorIndex` stays 7. `Done` still pulses.
- **Wrap-around:** seeds 0x8000, 0x8000, entry 2 = 0x0000, the rest following the mod-2^16 recurrence → `Error`=0.
- **Start ignored while busy:** a second Start during HOLD of entry 4 → scan completes unchanged in 112 cycles, exactly one `Done`. A following Start in IDLE clears `Error` and rescans.
- **Reset mid-scan:** assert `Reset` during entry 9 → all outputs 0 asynchronously, state IDLE, no `Done`. Start after release → full scan from index 0.
- **`DWELL`=1:** each entry lasts 3 cycles, total 48 busy cycles, and the captured values match the normal-scan case.
